theremin_period_meter: RTL and testbench

Measures the period of the asynchronous theremin oscillator square wave in system-clock cycles and averages it over a power-of-two number of periods. It produces a left-justified fixed-point period value that is held between updates. The block sits directly upstream of the power-of-two IIR smoothing filter: OUT_VALUE drives the filter's IN_VALUE channel input, one instance per oscillator channel (A/B).

---
 rtl/theremin_period_meter.sv | 164 ++++++++++++++++
 tb/tb_theremin_period_meter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/theremin_period_meter.sv
// theremin_period_meter
// Measures the period of an asynchronous oscillator square wave in system
// clock cycles, sums 2^AVG_SHIFT consecutive periods and presents the sum
// left-justified in OUT_VALUE. A stalled or too-slow oscillator raises
// TIMEOUT, which stays set until the next complete group is published.
// DATA_BITS must be at least COUNTER_BITS + AVG_SHIFT.

module theremin_period_meter #(
    parameter int DATA_BITS    = 32,
    parameter int COUNTER_BITS = 16,
    parameter int AVG_SHIFT    = 4
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 FREQ_IN,
    output logic [DATA_BITS-1:0] OUT_VALUE,
    output logic                 OUT_VALID,
    output logic                 TIMEOUT
);

    // Accumulator holds up to 2^AVG_SHIFT periods of at most 2^COUNTER_BITS-1
    // cycles each, so this width can never overflow.
    localparam int ACC_BITS  = COUNTER_BITS + AVG_SHIFT;
    localparam int OUT_SHIFT = DATA_BITS - ACC_BITS;

    localparam logic [COUNTER_BITS-1:0] CNT_ZERO    = {COUNTER_BITS{1'b0}};
    localparam logic [COUNTER_BITS-1:0] CNT_ONE     = COUNTER_BITS'(1'b1);
    // Last count value at which an edge still yields a valid period
    // (2^COUNTER_BITS - 1 cycles); without an edge here the oscillator is lost.
    localparam logic [COUNTER_BITS-1:0] CNT_TIMEOUT = {{(COUNTER_BITS-1){1'b1}}, 1'b0};

    localparam logic [ACC_BITS-1:0]     ACC_ZERO    = {ACC_BITS{1'b0}};
    localparam logic [ACC_BITS-1:0]     ACC_ONE     = ACC_BITS'(1'b1);

    localparam logic [AVG_SHIFT-1:0]    IDX_ZERO    = {AVG_SHIFT{1'b0}};
    localparam logic [AVG_SHIFT-1:0]    IDX_ONE     = AVG_SHIFT'(1'b1);
    localparam logic [AVG_SHIFT-1:0]    IDX_LAST    = {AVG_SHIFT{1'b1}};

    typedef enum logic [0:0] {
        ST_WAIT_FIRST = 1'b0,
        ST_MEASURE    = 1'b1
    } state_t;

    // Synchroniser chain plus the delay stage used for rising-edge detection
    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic                    sync3_q, sync3_d;

    // Measurement state
    state_t                  state_q, state_d;
    logic [COUNTER_BITS-1:0] cnt_q,   cnt_d;
    logic [ACC_BITS-1:0]     acc_q,   acc_d;
    logic [AVG_SHIFT-1:0]    idx_q,   idx_d;

    // Output registers
    logic [DATA_BITS-1:0]    out_value_q, out_value_d;
    logic                    out_valid_q, out_valid_d;
    logic                    timeout_q,   timeout_d;

    // Combinational helpers
    logic                    edge_s;
    logic [ACC_BITS-1:0]     period_s;
    logic [ACC_BITS-1:0]     acc_sum_s;

    // Synchroniser shift, edge detection and the free-running period counter
    always_comb begin
        sync1_d   = FREQ_IN;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        edge_s    = sync2_q & ~sync3_q;
        period_s  = ACC_BITS'(cnt_q) + ACC_ONE;
        acc_sum_s = acc_q + period_s;
        if (edge_s) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Next-state and output logic of the measurement FSM
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_value_d = out_value_q;
        out_valid_d = 1'b0;
        timeout_d   = timeout_q;

        case (state_q)
            ST_WAIT_FIRST: begin
                // The first edge only opens the measurement window
                if (edge_s) begin
                    acc_d   = ACC_ZERO;
                    idx_d   = IDX_ZERO;
                    state_d = ST_MEASURE;
                end else begin
                    state_d = ST_WAIT_FIRST;
                end
            end

            ST_MEASURE: begin
                // An edge takes priority over the timeout on the same cycle
                if (edge_s) begin
                    if (idx_q == IDX_LAST) begin
                        out_value_d = DATA_BITS'(acc_sum_s) << OUT_SHIFT;
                        out_valid_d = 1'b1;
                        timeout_d   = 1'b0;
                        acc_d       = ACC_ZERO;
                        idx_d       = IDX_ZERO;
                    end else begin
                        acc_d = acc_sum_s;
                        idx_d = idx_q + IDX_ONE;
                    end
                end else if (cnt_q == CNT_TIMEOUT) begin
                    timeout_d = 1'b1;
                    acc_d     = ACC_ZERO;
                    idx_d     = IDX_ZERO;
                    state_d   = ST_WAIT_FIRST;
                end else begin
                    state_d = ST_MEASURE;
                end
            end

            default: begin
                // Unreachable encoding: restart measurement cleanly
                state_d = ST_WAIT_FIRST;
                acc_d   = ACC_ZERO;
                idx_d   = IDX_ZERO;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            state_q     <= ST_WAIT_FIRST;
            cnt_q       <= CNT_ZERO;
            acc_q       <= ACC_ZERO;
            idx_q       <= IDX_ZERO;
            out_value_q <= {DATA_BITS{1'b0}};
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_value_q <= out_value_d;
            out_valid_q <= out_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign OUT_VALUE = out_value_q;
    assign OUT_VALID = out_valid_q;
    assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_theremin_period_meter.sv
// Directed bench for theremin_period_meter. Two instances share the clock:
// instance A runs the steady, alternating, minimum-period, reset and
// maximum-period scenarios; instance B runs the oscillator-stop scenario
// alongside so the long waits overlap.

module tb_theremin_period_meter;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        freq_a = 1'b0;
    logic        freq_b = 1'b0;
    logic [31:0] val_a, val_b;
    logic        valid_a, valid_b;
    logic        to_a, to_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Output monitors (captured on the falling edge)
    int          vcnt_a = 0, vcnt_b = 0;
    logic [31:0] vval_a = 32'h0, vval_b = 32'h0;
    int          vcyc_a = 0, vcyc_b = 0;
    logic        vto_a = 1'b0, vto_b = 1'b0;
    logic        valid_a_d = 1'b0, valid_b_d = 1'b0;
    int          wide_a = 0, wide_b = 0;
    int          tocnt_a = 0;

    int t_mark_a, prev_a, base_a, tosnap_a;
    int t_mark_b, t_last_b;

    theremin_period_meter #(
        .DATA_BITS(32), .COUNTER_BITS(16), .AVG_SHIFT(4)
    ) u_dut_a (
        .CLK(clk), .RESETN(rst_a), .FREQ_IN(freq_a),
        .OUT_VALUE(val_a), .OUT_VALID(valid_a), .TIMEOUT(to_a)
    );

    theremin_period_meter #(
        .DATA_BITS(32), .COUNTER_BITS(16), .AVG_SHIFT(4)
    ) u_dut_b (
        .CLK(clk), .RESETN(rst_b), .FREQ_IN(freq_b),
        .OUT_VALUE(val_b), .OUT_VALID(valid_b), .TIMEOUT(to_b)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for instance A
    always @(negedge clk) begin
        if (valid_a) begin
            vcnt_a <= vcnt_a + 1;
            vval_a <= val_a;
            vcyc_a <= cyc;
            vto_a  <= to_a;
        end
        if (valid_a && valid_a_d) wide_a <= wide_a + 1;
        valid_a_d <= valid_a;
        if (to_a) tocnt_a <= tocnt_a + 1;
    end

    // Monitor for instance B
    always @(negedge clk) begin
        if (valid_b) begin
            vcnt_b <= vcnt_b + 1;
            vval_b <= val_b;
            vcyc_b <= cyc;
            vto_b  <= to_b;
        end
        if (valid_b && valid_b_d) wide_b <= wide_b + 1;
        valid_b_d <= valid_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One oscillator period of n clocks starting with a rising edge; called
    // and returning at 1 ns after a rising clock edge.
    task automatic period_a(input int n);
        int h;
        h = n / 2;
        freq_a = 1'b1;
        repeat (h) @(posedge clk);
        #1 freq_a = 1'b0;
        repeat (n - h) @(posedge clk);
        #1;
    endtask

    task automatic period_b(input int n);
        int h;
        h = n / 2;
        freq_b = 1'b1;
        repeat (h) @(posedge clk);
        #1 freq_b = 1'b0;
        repeat (n - h) @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        freq_a = 1'b0;
        rst_a  = 1'b0;
        #1;
        chk("a_reset_value", val_a, 32'h0);
        chk("a_reset_valid", {31'h0, valid_a}, 32'h0);
        chk("a_reset_timeout", {31'h0, to_a}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_b();
        freq_b = 1'b0;
        rst_b  = 1'b0;
        #1;
        chk("b_reset_value", val_b, 32'h0);
        chk("b_reset_timeout", {31'h0, to_b}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        fork
            begin : branch_a
                // Steady 100-clock period from reset
                reset_a();
                repeat (16) period_a(100);
                chk("t1_no_early_valid", vcnt_a, 32'd0);
                t_mark_a = cyc;
                period_a(100);
                chk("t1_first_valid", vcnt_a, 32'd1);
                chk("t1_latency", vcyc_a - t_mark_a, 32'd3);
                chk("t1_value", vval_a, 32'h00640000);
                prev_a = vcyc_a;
                repeat (16) period_a(100);
                chk("t1_second_valid", vcnt_a, 32'd2);
                chk("t1_interval", vcyc_a - prev_a, 32'd1600);
                chk("t1_value2", vval_a, 32'h00640000);
                chk("t1_timeout", {31'h0, to_a}, 32'h0);
                chk("t1_hold", val_a, 32'h00640000);

                // Alternating 100/101-clock periods
                reset_a();
                base_a = vcnt_a;
                for (int i = 0; i < 16; i++) period_a((i % 2) ? 101 : 100);
                period_a(100);
                chk("t2_count1", vcnt_a - base_a, 32'd1);
                chk("t2_value1", vval_a, 32'h00648000);
                for (int i = 0; i < 15; i++) period_a((i % 2 == 0) ? 101 : 100);
                period_a(100);
                chk("t2_count2", vcnt_a - base_a, 32'd2);
                chk("t2_value2", vval_a, 32'h00648000);

                // Minimum period of 2 clocks
                reset_a();
                base_a = vcnt_a;
                repeat (17) period_a(2);
                repeat (4) @(posedge clk);
                #1;
                chk("t3_count", vcnt_a - base_a, 32'd1);
                chk("t3_value", vval_a, 32'h00020000);

                // Asynchronous reset in the middle of a group
                reset_a();
                repeat (17) period_a(100);
                chk("t6_pre_value", val_a, 32'h00640000);
                repeat (5) period_a(100);
                #3 rst_a = 1'b0;
                #1;
                chk("t6_async_value", val_a, 32'h0);
                chk("t6_async_valid", {31'h0, valid_a}, 32'h0);
                chk("t6_async_timeout", {31'h0, to_a}, 32'h0);
                #2 rst_a = 1'b1;
                @(posedge clk);
                #1;
                base_a = vcnt_a;
                repeat (16) period_a(100);
                chk("t6_no_early_valid", vcnt_a - base_a, 32'd0);
                t_mark_a = cyc;
                period_a(100);
                chk("t6_count", vcnt_a - base_a, 32'd1);
                chk("t6_latency", vcyc_a - t_mark_a, 32'd3);
                chk("t6_value", vval_a, 32'h00640000);

                // One maximum-length period of 65535 clocks inside the group
                reset_a();
                base_a   = vcnt_a;
                tosnap_a = tocnt_a;
                repeat (7) period_a(100);
                period_a(65535);
                repeat (8) period_a(100);
                chk("t5_no_early_valid", vcnt_a - base_a, 32'd0);
                period_a(100);
                chk("t5_count", vcnt_a - base_a, 32'd1);
                chk("t5_value", vval_a, 32'h105DB000);
                chk("t5_no_timeout", tocnt_a - tosnap_a, 32'd0);
            end

            begin : branch_b
                // Oscillator stops after a valid output, then restarts
                reset_b();
                repeat (16) period_b(100);
                t_last_b = cyc;
                period_b(100);
                chk("t4_first_valid", vcnt_b, 32'd1);
                chk("t4_value", vval_b, 32'h00640000);
                while (cyc < t_last_b + 3 + 65534) @(negedge clk);
                chk("t4_timeout_not_yet", {31'h0, to_b}, 32'h0);
                @(negedge clk);
                chk("t4_timeout_rise", {31'h0, to_b}, 32'h1);
                chk("t4_hold_value", val_b, 32'h00640000);
                chk("t4_no_valid", vcnt_b, 32'd1);
                @(posedge clk);
                #1;
                repeat (16) period_b(100);
                chk("t4_timeout_held", {31'h0, to_b}, 32'h1);
                chk("t4_restart_no_valid", vcnt_b, 32'd1);
                t_mark_b = cyc;
                period_b(100);
                chk("t4_restart_valid", vcnt_b, 32'd2);
                chk("t4_restart_latency", vcyc_b - t_mark_b, 32'd3);
                chk("t4_timeout_clear_with_valid", {31'h0, vto_b}, 32'h0);
                chk("t4_timeout_clear", {31'h0, to_b}, 32'h0);
                chk("t4_restart_value", vval_b, 32'h00640000);
            end
        join

        chk("valid_pulse_width", wide_a + wide_b, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
